uart_tx_cfg: RTL and testbench

//  Parametrised UART transmitter. Serialises one NB_DATA-bit word per frame with runtime-selectable

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 21 ++
 rtl/uart_tx_cfg.sv | 78 +++++++
 tb/tb_uart_tx_cfg.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encodings, parity-mode constants and width helper.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts oversampling ticks and strobes bit_end on the last tick of each bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int NB_OVS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic bit_end
);
  localparam int CW = clogb2(NB_OVS);
  localparam logic [CW-1:0] LAST = CW'(NB_OVS - 1);
  logic [CW-1:0] cnt;
  assign bit_end = !clear && tick && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick) cnt <= bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with runtime parity (none/even/odd) and 1 or 2 stop bits.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OVS  = 16
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [1:0]         i_parity_mode,
  input  logic               i_two_stop,
  output logic               o_ready,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);
  localparam int BW = clogb2(NB_DATA);
  localparam logic [BW-1:0] LAST_BIT = BW'(NB_DATA - 1);
  tx_state_e state, state_d;
  logic [NB_DATA-1:0] shift, shift_d;
  logic [BW-1:0] bit_idx;
  logic stop_idx, par_en, par_bit, two_stop, bit_end, xfer, last_stop, tx_d;
  assign xfer = i_valid && o_ready;
  assign last_stop = !two_stop || stop_idx;
  uart_bit_timer #(.NB_OVS(NB_OVS)) u_timer (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .clear  (state == ST_IDLE),
    .tick   (i_tick),
    .bit_end(bit_end)
  );
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else state <= state_d;
  always_comb begin
    state_d = ST_IDLE;
    case (state)
      ST_IDLE:   state_d = xfer ? ST_START : ST_IDLE;
      ST_START:  state_d = bit_end ? ST_DATA : ST_START;
      ST_DATA:   state_d = !(bit_end && bit_idx == LAST_BIT) ? ST_DATA : par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: state_d = bit_end ? ST_STOP : ST_PARITY;
      ST_STOP:   state_d = (bit_end && last_stop) ? ST_IDLE : ST_STOP;
      default:   state_d = ST_IDLE;
    endcase
  end
  // o_tx is registered from the next state so the line moves on the same edge as the FSM
  always_comb begin
    o_ready = state == ST_IDLE;
    o_busy  = !o_ready;
    o_done  = state == ST_STOP && bit_end && last_stop;
    shift_d = xfer ? i_data : (state == ST_DATA && bit_end) ? shift >> 1 : shift;
    tx_d    = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? shift_d[0] :
              state_d == ST_PARITY ? par_bit : 1'b1;
  end
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
      o_tx     <= 1'b1;
    end else begin
      shift <= shift_d;
      o_tx  <= tx_d;
      if (xfer) begin
        par_en   <= i_parity_mode == PAR_EVEN || i_parity_mode == PAR_ODD;
        par_bit  <= i_parity_mode == PAR_ODD ? ~^i_data : ^i_data;
        two_stop <= i_two_stop;
      end
      if (state == ST_DATA && bit_end) bit_idx <= bit_idx == LAST_BIT ? '0 : bit_idx + 1'b1;
      if (state == ST_STOP && bit_end) stop_idx <= !last_stop;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frames with hand-built expected bit patterns, checked by a line monitor.
module tb_uart_tx_cfg;
  import uart_pkg::*;
  logic clk = 1'b0, i_rst_n = 1'b1, i_tick = 1'b0, i_valid = 1'b0, i_two_stop = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [1:0] i_parity_mode = 2'b00;
  logic o_ready, o_tx, o_busy, o_done;
  typedef struct {
    logic [11:0] bits;
    int          n;
    bit          b2b;
    bit          abort;
  } frame_t;
  frame_t exp_q[$];
  int n_tests = 0, n_fail = 0, n_done = 0;
  bit mon_idle = 1'b1;

  uart_tx_cfg #(.NB_DATA(8), .NB_OVS(16)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_tick       (i_tick),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_parity_mode(i_parity_mode),
    .i_two_stop   (i_two_stop),
    .o_ready      (o_ready),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  initial begin
    int t;
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      t++;
      i_tick = (t % 4 == 0);
    end
  end

  always @(negedge clk) if (o_done) n_done++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Line monitor: detects a start bit, samples mid-bit and checks o_done on the final tick
  initial begin
    frame_t e;
    logic [11:0] got;
    int tk;
    bit aborted;
    time done_t, start_t;
    done_t = 0;
    forever begin
      @(negedge clk);
      if (i_rst_n && o_tx === 1'b0) begin
        mon_idle = 1'b0;
        start_t = $time;
        if (exp_q.size() == 0) begin
          timeout("unexpected_frame");
          e = '{12'h0, 10, 1'b0, 1'b0};
        end else e = exp_q.pop_front();
        check("busy_at_start", {30'd0, o_busy, o_ready}, 32'b10);
        if (e.b2b) check("b2b_gap_ns", 32'(start_t - done_t), 20);
        got = '0;
        tk = 0;
        aborted = 1'b0;
        while (1) begin
          if (!i_rst_n) begin
            aborted = 1'b1;
            break;
          end
          if (i_tick) begin
            tk++;
            if (tk % 16 == 8) got[tk/16] = o_tx;
            if (tk == 16 * e.n) begin
              check("done_at_end", {31'd0, o_done}, 1);
              done_t = $time;
              break;
            end
          end
          @(negedge clk);
        end
        check("abort_flag", {31'd0, aborted}, {31'd0, e.abort});
        if (!aborted) begin
          check("frame_bits", {20'd0, got}, {20'd0, e.bits});
          @(negedge clk);
          check("idle_after_done", {29'd0, o_ready, o_busy, o_tx}, 32'b101);
        end
        mon_idle = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic two,
                      input logic [11:0] eb, input int n, input bit b2b, input bit ab, input bit hold);
    frame_t f;
    bit ok;
    f.bits = eb;
    f.n = n;
    f.b2b = b2b;
    f.abort = ab;
    exp_q.push_back(f);
    i_data = d;
    i_parity_mode = m;
    i_two_stop = two;
    i_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept_timeout");
    @(posedge clk);
    #1;
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!o_busy && mon_idle && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 i_rst_n = 1'b0;
    #1 check("reset_outputs", {28'd0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {28'd0, o_tx, o_ready, o_busy, o_done}, 32'b1100);
    @(posedge clk);
    #1;
    send(8'hA5, PAR_NONE, 1'b0, {1'b1, 8'hA5, 1'b0}, 10, 0, 0, 0);
    wait_idle();
    send(8'h03, PAR_EVEN, 1'b0, {1'b1, 1'b0, 8'h03, 1'b0}, 11, 0, 0, 0);
    wait_idle();
    send(8'h03, PAR_ODD, 1'b0, {1'b1, 1'b1, 8'h03, 1'b0}, 11, 0, 0, 0);
    wait_idle();
    send(8'h03, 2'b11, 1'b0, {1'b1, 8'h03, 1'b0}, 10, 0, 0, 0);
    wait_idle();
    send(8'hFF, PAR_NONE, 1'b1, {2'b11, 8'hFF, 1'b0}, 11, 0, 0, 0);
    wait_idle();
    send(8'h11, PAR_NONE, 1'b0, {1'b1, 8'h11, 1'b0}, 10, 0, 0, 1);
    send(8'h22, PAR_NONE, 1'b0, {1'b1, 8'h22, 1'b0}, 10, 1, 0, 0);
    wait_idle();
    send(8'h5A, PAR_EVEN, 1'b0, {1'b1, 1'b0, 8'h5A, 1'b0}, 11, 0, 0, 0);
    repeat (50) @(posedge clk);
    #1;
    i_data = 8'hC3;
    i_parity_mode = PAR_ODD;
    i_two_stop = 1'b1;
    i_valid = 1'b1;
    @(negedge clk);
    check("ready_while_busy", {31'd0, o_ready}, 0);
    send(8'hC3, PAR_ODD, 1'b1, {2'b11, 1'b1, 8'hC3, 1'b0}, 12, 1, 0, 0);
    wait_idle();
    send(8'h96, PAR_NONE, 1'b0, {1'b1, 8'h96, 1'b0}, 10, 0, 1, 0);
    repeat (288) @(posedge clk);
    #2 i_rst_n = 1'b0;
    #1 check("rst_async", {28'd0, o_tx, o_busy, o_ready, o_done}, 32'b1010);
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    send(8'h3C, PAR_ODD, 1'b0, {1'b1, 1'b1, 8'h3C, 1'b0}, 11, 0, 0, 0);
    wait_idle();
    repeat (4) @(posedge clk);
    check("done_pulse_count", n_done, 10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
